// File: rtl/search_scheduler.sv
// search_scheduler
//
// Runs one engine search per UCI `go`. A `go` is only accepted once a
// position has been loaded (ARMED). The search gets a millisecond budget;
// when it runs out, or the GUI sends `stop`, the engine is aborted and given
// STOP_GRACE cycles to hand back its best move. If it stays silent, a null
// move is reported and the sticky timeout flag is set. Loading a new position
// mid-search cancels the search and suppresses its result.
//
// Ports
//   clk_in, rst_in       clock, synchronous active-high reset
//   board_valid_in       pulse: new position loaded into the engine
//   go_in / stop_in      pulses: UCI go / stop
//   movetime_ms_in       budget in ms, sampled on accepted go (0 = infinite)
//   depth_in             depth limit, sampled on accepted go
//   ec_ready_in          engine idle and able to start
//   ec_move_in/valid_in  engine best move and its qualifying pulse
//   ec_go_out            one-cycle engine start pulse
//   ec_abort_out         level, high while the engine is being stopped
//   ec_depth_out         depth latched for the current search
//   bestmove_out/valid   result to the UCI handler, one-cycle pulse
//   busy_out             high while a search is starting, running or stopping
//   timeout_out          sticky: engine missed the grace period
module search_scheduler #(
    parameter int MOVE_W     = 16,
    parameter int CLK_PER_MS = 40000,
    parameter int STOP_GRACE = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              board_valid_in,
    input  logic              go_in,
    input  logic              stop_in,
    input  logic [15:0]       movetime_ms_in,
    input  logic [3:0]        depth_in,
    input  logic              ec_ready_in,
    input  logic [MOVE_W-1:0] ec_move_in,
    input  logic              ec_valid_in,
    output logic              ec_go_out,
    output logic              ec_abort_out,
    output logic [3:0]        ec_depth_out,
    output logic [MOVE_W-1:0] bestmove_out,
    output logic              bestmove_valid_out,
    output logic              busy_out,
    output logic              timeout_out
);

    localparam int PRE_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int GRACE_W = (STOP_GRACE > 1) ? $clog2(STOP_GRACE) : 1;
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_PER_MS - 1);
    localparam logic [GRACE_W-1:0] GRACE_LAST = GRACE_W'(STOP_GRACE - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        SEARCH,
        STOPPING
    } state_t;

    state_t              state, state_nxt;
    logic [PRE_W-1:0]    prescale, prescale_nxt;
    logic [15:0]         ms_cnt, ms_cnt_nxt;
    logic [GRACE_W-1:0]  grace, grace_nxt;
    logic [15:0]         movetime, movetime_nxt;
    logic [3:0]          depth, depth_nxt;
    logic                discard, discard_nxt;
    logic                timeout, timeout_nxt;
    logic                go_pulse, go_pulse_nxt;
    logic [MOVE_W-1:0]   bestmove, bestmove_nxt;
    logic                bm_valid, bm_valid_nxt;
    logic                deadline;
    logic                drop_now;

    // Elapsed-ms counter saturates so a very long infinite search cannot
    // wrap around and spuriously match a budget.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign deadline = (movetime != 16'd0) && (ms_cnt == movetime);

    // A result arriving while a new position is being loaded belongs to the
    // old position and must be dropped.
    assign drop_now = discard || board_valid_in;

    always_comb begin
        state_nxt    = state;
        prescale_nxt = prescale;
        ms_cnt_nxt   = ms_cnt;
        grace_nxt    = grace;
        movetime_nxt = movetime;
        depth_nxt    = depth;
        discard_nxt  = discard;
        timeout_nxt  = timeout;
        go_pulse_nxt = 1'b0;
        bestmove_nxt = bestmove;
        bm_valid_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (board_valid_in) begin
                    state_nxt = ARMED;
                end
            end

            ARMED: begin
                // go wins over a simultaneous stop; stop is meaningless here
                if (go_in) begin
                    movetime_nxt = movetime_ms_in;
                    depth_nxt    = depth_in;
                    timeout_nxt  = 1'b0;
                    prescale_nxt = '0;
                    ms_cnt_nxt   = '0;
                    state_nxt    = START;
                end
            end

            START: begin
                // The engine has not been started yet, so a cancel needs no
                // abort handshake.
                if (board_valid_in || stop_in) begin
                    state_nxt = ARMED;
                end else if (ec_ready_in) begin
                    go_pulse_nxt = 1'b1;
                    discard_nxt  = 1'b0;
                    state_nxt    = SEARCH;
                end
            end

            SEARCH: begin
                if (prescale == PRE_LAST) begin
                    prescale_nxt = '0;
                    ms_cnt_nxt   = sat_inc16(ms_cnt);
                end else begin
                    prescale_nxt = prescale + 1'b1;
                end

                if (board_valid_in) begin
                    if (ec_valid_in) begin
                        state_nxt = ARMED;
                    end else begin
                        discard_nxt = 1'b1;
                        grace_nxt   = '0;
                        state_nxt   = STOPPING;
                    end
                end else if (ec_valid_in) begin
                    // A result in the same cycle as deadline/stop wins.
                    bestmove_nxt = ec_move_in;
                    bm_valid_nxt = 1'b1;
                    state_nxt    = ARMED;
                end else if (deadline || stop_in) begin
                    discard_nxt = 1'b0;
                    grace_nxt   = '0;
                    state_nxt   = STOPPING;
                end
            end

            STOPPING: begin
                grace_nxt = grace + 1'b1;
                if (ec_valid_in) begin
                    if (!drop_now) begin
                        bestmove_nxt = ec_move_in;
                        bm_valid_nxt = 1'b1;
                    end
                    state_nxt = ARMED;
                end else if (grace == GRACE_LAST) begin
                    if (!drop_now) begin
                        bestmove_nxt = '0;
                        bm_valid_nxt = 1'b1;
                        timeout_nxt  = 1'b1;
                    end
                    state_nxt = ARMED;
                end else if (board_valid_in) begin
                    discard_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            prescale <= '0;
            ms_cnt   <= '0;
            grace    <= '0;
            movetime <= '0;
            depth    <= '0;
            discard  <= 1'b0;
            timeout  <= 1'b0;
            go_pulse <= 1'b0;
            bestmove <= '0;
            bm_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            prescale <= prescale_nxt;
            ms_cnt   <= ms_cnt_nxt;
            grace    <= grace_nxt;
            movetime <= movetime_nxt;
            depth    <= depth_nxt;
            discard  <= discard_nxt;
            timeout  <= timeout_nxt;
            go_pulse <= go_pulse_nxt;
            bestmove <= bestmove_nxt;
            bm_valid <= bm_valid_nxt;
        end
    end

    // Abort is exactly "in STOPPING"; a reset drops it on the next cycle.
    assign ec_abort_out       = (state == STOPPING);
    assign busy_out           = (state == START) || (state == SEARCH) || (state == STOPPING);
    assign ec_go_out          = go_pulse;
    assign ec_depth_out       = depth;
    assign bestmove_out       = bestmove;
    assign bestmove_valid_out = bm_valid;
    assign timeout_out        = timeout;

endmodule

// File: tb/tb_search_scheduler.sv
module tb_search_scheduler;

    localparam int MOVE_W = 16;
    localparam int CPM    = 4;
    localparam int GRACE  = 8;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_START  = 2;
    localparam int M_SEARCH = 3;
    localparam int M_STOP   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              bv;
    logic              go;
    logic              stop;
    logic [15:0]       mt;
    logic [3:0]        dep;
    logic              rdy;
    logic [MOVE_W-1:0] mv;
    logic              vld;

    logic              ec_go;
    logic              ec_abort;
    logic [3:0]        ec_depth;
    logic [MOVE_W-1:0] bestmove;
    logic              bestmove_valid;
    logic              busy;
    logic              timeout;

    always #5 clk = ~clk;

    search_scheduler #(
        .MOVE_W    (MOVE_W),
        .CLK_PER_MS(CPM),
        .STOP_GRACE(GRACE)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .board_valid_in    (bv),
        .go_in             (go),
        .stop_in           (stop),
        .movetime_ms_in    (mt),
        .depth_in          (dep),
        .ec_ready_in       (rdy),
        .ec_move_in        (mv),
        .ec_valid_in       (vld),
        .ec_go_out         (ec_go),
        .ec_abort_out      (ec_abort),
        .ec_depth_out      (ec_depth),
        .bestmove_out      (bestmove),
        .bestmove_valid_out(bestmove_valid),
        .busy_out          (busy),
        .timeout_out       (timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: search phase plus timestamps; elapsed ms and grace
    // are derived arithmetically from the cycle of ec_go / first abort cycle.
    int        m_phase;
    int        m_go_at;
    int        m_stop_at;
    int        m_mt;
    bit        m_drop;
    bit        e_go;
    bit        e_bmv;
    bit        e_timeout;
    bit [3:0]  e_depth;
    bit [15:0] e_bm;
    int        cyc = 0;

    task automatic model_step(input bit r, input bit b, input bit g, input bit s,
                              input bit [15:0] t, input bit [3:0] d, input bit rd,
                              input bit [15:0] m, input bit v, input int c);
        int ms;
        bit drop;
        e_go  = 1'b0;
        e_bmv = 1'b0;
        if (r) begin
            m_phase   = M_IDLE;
            m_mt      = 0;
            m_drop    = 1'b0;
            e_depth   = 4'd0;
            e_bm      = 16'd0;
            e_timeout = 1'b0;
            return;
        end
        case (m_phase)
            M_IDLE: if (b) m_phase = M_ARMED;
            M_ARMED: begin
                if (g) begin
                    m_mt      = int'(t);
                    e_depth   = d;
                    e_timeout = 1'b0;
                    m_phase   = M_START;
                end
            end
            M_START: begin
                if (b || s) m_phase = M_ARMED;
                else if (rd) begin
                    e_go    = 1'b1;
                    m_go_at = c + 1;
                    m_phase = M_SEARCH;
                end
            end
            M_SEARCH: begin
                ms = (c - m_go_at) / CPM;
                if (ms > 65535) ms = 65535;
                if (b) begin
                    if (v) m_phase = M_ARMED;
                    else begin
                        m_drop    = 1'b1;
                        m_stop_at = c + 1;
                        m_phase   = M_STOP;
                    end
                end else if (v) begin
                    e_bm    = m;
                    e_bmv   = 1'b1;
                    m_phase = M_ARMED;
                end else if ((m_mt != 0 && ms == m_mt) || s) begin
                    m_drop    = 1'b0;
                    m_stop_at = c + 1;
                    m_phase   = M_STOP;
                end
            end
            M_STOP: begin
                drop = m_drop || b;
                if (v) begin
                    if (!drop) begin
                        e_bm  = m;
                        e_bmv = 1'b1;
                    end
                    m_phase = M_ARMED;
                end else if (c - m_stop_at == GRACE - 1) begin
                    if (!drop) begin
                        e_bm      = 16'd0;
                        e_bmv     = 1'b1;
                        e_timeout = 1'b1;
                    end
                    m_phase = M_ARMED;
                end else if (b) begin
                    m_drop = 1'b1;
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    // Observed-event statistics for the directed scenarios.
    int        n_go;
    int        n_bmv;
    int        go_at;
    int        abort_rise;
    int        bmv_at;
    bit        abort_seen;
    bit        abort_prev;
    bit [15:0] last_bm;

    task automatic clear_stats();
        n_go       = 0;
        n_bmv      = 0;
        go_at      = -1;
        abort_rise = -1;
        bmv_at     = -1;
        abort_seen = 1'b0;
        last_bm    = 16'hDEAD;
    endtask

    task automatic tick();
        bit r, b, g, s, rd, v;
        bit [15:0] t, m;
        bit [3:0] d;
        bit exp_busy;
        @(posedge clk);
        r = rst; b = bv; g = go; s = stop; rd = rdy; v = vld;
        t = mt; m = mv; d = dep;
        #1;
        model_step(r, b, g, s, t, d, rd, m, v, cyc);
        cyc++;
        exp_busy = (m_phase == M_START) || (m_phase == M_SEARCH) || (m_phase == M_STOP);
        chk("ec_go",          32'(ec_go),          32'(e_go));
        chk("ec_abort",       32'(ec_abort),       32'(m_phase == M_STOP));
        chk("ec_depth",       32'(ec_depth),       32'(e_depth));
        chk("bestmove_valid", 32'(bestmove_valid), 32'(e_bmv));
        chk("bestmove",       32'(bestmove),       32'(e_bm));
        chk("busy",           32'(busy),           32'(exp_busy));
        chk("timeout",        32'(timeout),        32'(e_timeout));
        if (ec_go === 1'b1) begin
            n_go++;
            go_at = cyc;
        end
        if (ec_abort === 1'b1 && !abort_prev) begin
            abort_seen = 1'b1;
            abort_rise = cyc;
        end
        abort_prev = (ec_abort === 1'b1);
        if (bestmove_valid === 1'b1) begin
            n_bmv++;
            last_bm = bestmove;
            bmv_at  = cyc;
        end
        rst = 1'b0; bv = 1'b0; go = 1'b0; stop = 1'b0; vld = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] all_outs;
        rst = 1'b1; bv = 1'b0; go = 1'b0; stop = 1'b0; vld = 1'b0;
        rdy = 1'b0; mt = 16'd0; dep = 4'd0; mv = '0;
        abort_prev = 1'b0;
        clear_stats();
        tick();
        rst = 1'b1;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);

        // Normal search
        clear_stats();
        bv = 1'b1; tick();
        mt = 16'd100; dep = 4'd5; rdy = 1'b1; go = 1'b1; tick();
        repeat (19) tick();
        mv = 16'h1234; vld = 1'b1; tick();
        repeat (3) tick();
        chk("normal_go_count", 32'(n_go), 32'd1);
        chk("normal_bm_count", 32'(n_bmv), 32'd1);
        chk("normal_bm",       32'(last_bm), 32'h1234);
        chk("normal_no_abort", 32'(abort_seen), 32'd0);
        chk("normal_depth",    32'(ec_depth), 32'd5);

        // Deadline
        clear_stats();
        mt = 16'd3; go = 1'b1; tick();
        for (int i = 0; i < 60 && !abort_seen; i++) tick();
        tick();
        tick();
        mv = 16'h0ABC; vld = 1'b1; tick();
        repeat (2) tick();
        chk("deadline_latency", 32'(abort_rise - go_at), 32'd13);
        chk("deadline_bm_count", 32'(n_bmv), 32'd1);
        chk("deadline_bm",      32'(last_bm), 32'h0ABC);
        chk("deadline_bm_at",   32'(bmv_at - abort_rise), 32'd3);

        // Grace timeout
        clear_stats();
        mt = 16'd1; go = 1'b1; tick();
        for (int i = 0; i < 60 && !abort_seen; i++) tick();
        for (int i = 0; i < 30 && n_bmv == 0; i++) tick();
        chk("grace_len",     32'(bmv_at - abort_rise), 32'd8);
        chk("grace_null_bm", 32'(last_bm), 32'h0000);
        chk("grace_timeout", 32'(timeout), 32'd1);
        chk("grace_armed",   32'(busy), 32'd0);
        mt = 16'd0; go = 1'b1; tick();
        chk("timeout_cleared", 32'(timeout), 32'd0);

        // Stop collides with result
        repeat (5) tick();
        clear_stats();
        stop = 1'b1; vld = 1'b1; mv = 16'h0042; tick();
        repeat (3) tick();
        chk("collide_no_abort", 32'(abort_seen), 32'd0);
        chk("collide_bm_count", 32'(n_bmv), 32'd1);
        chk("collide_bm",       32'(last_bm), 32'h0042);

        // New position mid-search
        clear_stats();
        go = 1'b1; tick();
        repeat (4) tick();
        bv = 1'b1; tick();
        repeat (3) tick();
        mv = 16'h0777; vld = 1'b1; tick();
        repeat (2) tick();
        chk("newpos_abort",    32'(abort_seen), 32'd1);
        chk("newpos_no_bm",    32'(n_bmv), 32'd0);
        chk("newpos_armed",    32'(busy), 32'd0);
        clear_stats();
        go = 1'b1; tick();
        repeat (3) tick();
        chk("newpos_next_go",  32'(n_go), 32'd1);
        mv = 16'h0101; vld = 1'b1; tick();
        tick();

        // Gating
        rst = 1'b1; tick();
        clear_stats();
        go = 1'b1; tick();
        repeat (3) tick();
        chk("gate_no_board_go", 32'(n_go), 32'd0);
        chk("gate_no_board_busy", 32'(busy), 32'd0);
        bv = 1'b1; tick();
        rdy = 1'b0; go = 1'b1; tick();
        repeat (3) tick();
        stop = 1'b1; tick();
        repeat (3) tick();
        chk("gate_cancel_go", 32'(n_go), 32'd0);
        chk("gate_cancel_bm", 32'(n_bmv), 32'd0);
        chk("gate_cancel_busy", 32'(busy), 32'd0);
        rdy = 1'b1; mt = 16'd0; dep = 4'd9; go = 1'b1; tick();
        repeat (5) tick();
        rst = 1'b1; tick();
        all_outs = {ec_go, ec_abort, ec_depth, bestmove_valid, bestmove, busy, timeout};
        chk("reset_mid_search", 32'(all_outs), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(999) == 0);
            bv   = ($urandom_range(99) < 3);
            go   = ($urandom_range(99) < 15);
            stop = ($urandom_range(99) < 3);
            rdy  = ($urandom_range(99) < 60);
            vld  = ($urandom_range(99) < 4);
            mt   = 16'($urandom_range(6));
            dep  = 4'($urandom_range(15));
            mv   = 16'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
